packet_rx_stream: RTL
=====================

# packet_rx_stream

Parametrised network-side packet receiver for the ITCH parser front end. Accepts framed beats (sof/eof/len/vld) from the MAC interface, which cannot be back-pressured. Buffers them in an internal FIFO and presents a valid/ready stream with byte keep, last and error flags to the message decoder. Detects framing faults and FIFO overflow, and terminates affected packets cleanly so downstream never sees an unterminated packet.

## Interface
- DATA_W, 64, beat width in bits; multiple of 8, power of two ≥ 16
- LEN_W, $clog2(DATA_W/8), width of rx_len_net
- DEPTH, 16, FIFO entries; power of two ≥ 4
- CNT_W, 16, statistics counter width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data_net  in  DATA_W  beat data, byte 0 in bits [7:0]
- rx_sof_net  in  1  first beat of packet
- rx_eof_net  in  1  last beat of packet
- rx_len_net  in  LEN_W  valid bytes in eof beat; 0 = all DATA_W/8 bytes
- rx_vld_net  in  1  beat present this cycle; no ready, never stalled
- out_data  out  DATA_W  beat data, invalid bytes forced to 0
- out_keep  out  DATA_W/8  byte enables, low-aligned contiguous
- out_last  out  1  final beat of packet
- out_err  out  1  packet is truncated or corrupt; valid only with out_last
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream accepts beat when out_vld && out_rdy
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- pkt_cnt, err_cnt, drop_cnt, frm_cnt  out  CNT_W each  statistics (see Configuration)

## Operation
- FSM states: IDLE, PKT, DROP. Reset → IDLE.
- IDLE:
  - vld&&sof&&!eof → write beat, go to PKT.
  - vld&&sof&&eof → write single-beat packet with last=1, stay in IDLE.
  - vld without sof → discard, frm_cnt+1.
- PKT:
  - vld&&!sof&&!eof → write beat.
  - vld&&eof → write it with last=1, keep from rx_len_net, go to IDLE.
  - vld&&sof → framing fault: write terminator beat (keep=0, data=0, last=1, err=1), frm_cnt+1, go to DROP. The new packet is discarded.
- DROP: discard every beat up to and including the next eof, then go to IDLE. sof in DROP is ignored.
- Keep for non-eof beats is all ones. For eof beats, keep = (1<<len)−1, or all ones when len=0.
- Overflow:
  - A write needed while level == DEPTH−1 (not itself an eof beat) → write it with last=1, err=1, keep as normal, go to DROP, err_cnt+1.
  - An eof beat at DEPTH−1 writes normally.
  - sof arriving while level == DEPTH → whole packet dropped, nothing written, drop_cnt+1. Go to DROP, or stay in IDLE if eof is also set.
- pkt_cnt increments on each last=1, err=0 write.
- All counters saturate at 2^CNT_W−1.
- Inputs with rx_vld_net=0 are ignored entirely.

## Timing
- Reset values: out_vld=0, out_last=0, out_err=0, out_keep=0, out_data=0, fifo_level=0, all counters 0, FIFO empty.
- Latency: beat sampled at edge t into an empty FIFO gives out_vld=1 after edge t, i.e. one cycle.
- FIFO is first-word-fall-through; outputs hold stable while out_vld && !out_rdy.
- Simultaneous write and read in the same cycle leaves level unchanged, including at level DEPTH−1 and at DEPTH.
- Read and write pointers wrap modulo DEPTH.
- fifo_level is registered and reflects the state after the current edge.
- rst asserted mid-packet: FIFO flushed, FSM → IDLE, counters cleared on the next edge. A beat presented in the reset cycle is discarded.

## Configuration
- RX_STATS_EN defined: the four counters are implemented as above.
- RX_STATS_EN not defined: counter outputs are tied to 0, with no counter flops. Data path and FSM are unchanged.

## Test plan
- Reset, then 3-beat packet (sof; mid; eof len=3) with out_rdy=1 → out beats 1 cycle later; keep FF, FF, 07; last only on beat 3; err=0; pkt_cnt=1.
- Single beat with sof&eof, len=0 → one beat, keep=FF, last=1; FSM stays in IDLE.
- sof, mid, then sof again → third write has keep=00, last=1, err=1; beats through the next eof discarded; frm_cnt=1.
- out_rdy=0, DEPTH=16, 20-beat packet → 15 data beats plus the 16th beat flagged last=1, err=1; remaining beats dropped; err_cnt=1. A following sof with FIFO still full → drop_cnt=1.
- Beat with vld, no sof, in IDLE → nothing written; frm_cnt=1. Then rst during a packet → level=0, out_vld=0 next cycle.

Source files
------------

// File: rtl/packet_rx_stream.sv
// Network-side packet receiver: framed MAC beats into a FWFT FIFO, out as a valid/ready stream.
// Define RX_STATS_EN to build the pkt/err/drop/frm statistics counters.
module packet_rx_stream #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = $clog2(DATA_W/8),
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data_net,
  input  logic                     rx_sof_net,
  input  logic                     rx_eof_net,
  input  logic [LEN_W-1:0]         rx_len_net,
  input  logic                     rx_vld_net,
  output logic [DATA_W-1:0]        out_data,
  output logic [DATA_W/8-1:0]      out_keep,
  output logic                     out_last,
  output logic                     out_err,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         frm_cnt
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int ENT_W  = DATA_W + KEEP_W + 2;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_HI   = LVL_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t state, state_n;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  rd_ent;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              full, hi;

  logic              wr_req, wr_fire, rd_fire;
  logic [KEEP_W-1:0] keep_eof, keep_beat, wr_keep;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last, wr_err;
  logic              inc_pkt, inc_err, inc_drop, inc_frm;

  assign full      = (level == LVL_FULL);
  assign hi        = (level == LVL_HI);
  assign keep_eof  = (rx_len_net == '0) ? '1
                   : (KEEP_W'(1) << rx_len_net) - KEEP_W'(1);
  assign keep_beat = rx_eof_net ? keep_eof : '1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr_req   = 1'b0;
    wr_keep  = keep_beat;
    wr_last  = 1'b0;
    wr_err   = 1'b0;
    inc_err  = 1'b0;
    inc_drop = 1'b0;
    inc_frm  = 1'b0;
    if (rx_vld_net) begin
      unique case (state)
        IDLE: begin
          if (!rx_sof_net) begin
            inc_frm = 1'b1;
          end else if (full) begin
            inc_drop = 1'b1;
            if (!rx_eof_net) state_n = DROP;
          end else if (rx_eof_net) begin
            wr_req  = 1'b1;
            wr_last = 1'b1;
          end else if (hi) begin
            wr_req  = 1'b1;
            wr_last = 1'b1;
            wr_err  = 1'b1;
            inc_err = 1'b1;
            state_n = DROP;
          end else begin
            wr_req  = 1'b1;
            state_n = PKT;
          end
        end
        PKT: begin
          if (rx_sof_net) begin
            // close the open packet; the intruding packet is discarded
            wr_req  = 1'b1;
            wr_keep = '0;
            wr_last = 1'b1;
            wr_err  = 1'b1;
            inc_frm = 1'b1;
            state_n = rx_eof_net ? IDLE : DROP;
          end else if (rx_eof_net) begin
            wr_req  = 1'b1;
            wr_last = 1'b1;
            state_n = IDLE;
          end else if (hi) begin
            wr_req  = 1'b1;
            wr_last = 1'b1;
            wr_err  = 1'b1;
            inc_err = 1'b1;
            state_n = DROP;
          end else begin
            wr_req  = 1'b1;
          end
        end
        DROP: begin
          if (rx_eof_net) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      wr_data[i*8 +: 8] = wr_keep[i] ? rx_data_net[i*8 +: 8] : 8'h00;
    end
  end

  assign rd_fire = out_vld && out_rdy;
  assign wr_fire = wr_req && (!full || rd_fire);
  assign inc_pkt = wr_fire && wr_last && !wr_err;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {wr_err, wr_last, wr_keep, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_fire, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_ent     = mem[rd_ptr];
  assign out_vld    = (level != '0);
  assign out_data   = out_vld ? rd_ent[DATA_W-1:0] : '0;
  assign out_keep   = out_vld ? rd_ent[DATA_W +: KEEP_W] : '0;
  assign out_last   = out_vld && rd_ent[DATA_W+KEEP_W];
  assign out_err    = out_vld && rd_ent[DATA_W+KEEP_W+1];
  assign fifo_level = level;

`ifdef RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
      frm_cnt  <= '0;
    end else begin
      if (inc_pkt  && pkt_cnt  != '1) pkt_cnt  <= pkt_cnt  + 1'b1;
      if (inc_err  && err_cnt  != '1) err_cnt  <= err_cnt  + 1'b1;
      if (inc_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (inc_frm  && frm_cnt  != '1) frm_cnt  <= frm_cnt  + 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{inc_pkt, inc_err, inc_drop, inc_frm};
  assign pkt_cnt  = '0;
  assign err_cnt  = '0;
  assign drop_cnt = '0;
  assign frm_cnt  = '0;
`endif

endmodule
